// File: rtl/itch_add_order_decoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : itch_add_order_decoder_pkg
//  Description : Shared ITCH Add Order types and constants (RTL and bench).
//  Revision    : 1.0 - initial release
// ============================================================================
package itch_add_order_decoder_pkg;

    localparam logic [7:0] ADD_MSG_TYPE = 8'h41;
    localparam int         ADD_MSG_LEN  = 36;
    localparam logic [7:0] BUY          = 8'h42;
    localparam logic [7:0] SELL         = 8'h53;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TRUNC    = 2'd1,
        ERR_OVERLONG = 2'd2,
        ERR_BAD_SIDE = 2'd3
    } itchErrCodeType;

    // Field order matches wire order, so the assembled byte stream casts directly.
    typedef struct packed {
        logic [7:0]  msgType;
        logic [15:0] locate;
        logic [15:0] trackNum;
        logic [47:0] timeStamp;
        logic [63:0] refNum;
        logic [7:0]  side;
        logic [31:0] shares;
        logic [63:0] stock;
        logic [31:0] price;
    } itchAddOrderType;

    function automatic logic isValidSide(input logic [7:0] side);
        return (side == BUY) || (side == SELL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/itch_add_order_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : itch_add_order_decoder_if
//  Description : Parser byte stream in, decoded order record and errors out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface itch_add_order_decoder_if;
    import itch_add_order_decoder_pkg::*;

    logic           itchDataValid;
    logic [7:0]     itchData;
    logic           packetLost;

    logic           orderValid;
    logic [15:0]    locate;
    logic [15:0]    trackNum;
    logic [47:0]    timeStamp;
    logic [63:0]    refNum;
    logic           buy;
    logic [31:0]    shares;
    logic [63:0]    stock;
    logic [31:0]    price;
    logic           errValid;
    itchErrCodeType errCode;
    logic           seqGap;

    modport master (
        output itchDataValid, itchData, packetLost,
        input  orderValid, locate, trackNum, timeStamp, refNum, buy,
               shares, stock, price, errValid, errCode, seqGap
    );

    modport slave (
        input  itchDataValid, itchData, packetLost,
        output orderValid, locate, trackNum, timeStamp, refNum, buy,
               shares, stock, price, errValid, errCode, seqGap
    );

endinterface
`default_nettype wire

// File: rtl/itch_add_order_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : itch_add_order_decoder
//  Description : Assembles ITCH Add Order messages into a field-split record.
//  Revision    : 1.0 - initial release
// ============================================================================
module itch_add_order_decoder
    import itch_add_order_decoder_pkg::*;
#(
    parameter bit          LOCATE_FILTER_EN = 1'b0,
    parameter logic [15:0] LOCATE_ID        = 16'hBE42
) (
    input  logic                     clkIn,
    input  logic                     rstBIn,
    itch_add_order_decoder_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_SKIP    = 2'd3;

    // Holds bytes 0..34; byte 35 is appended combinationally on the completing cycle.
    localparam int         c_SHIFT_W  = (ADD_MSG_LEN - 1) * 8;
    localparam logic [5:0] c_LAST_IDX = 6'(ADD_MSG_LEN - 1);
    localparam logic [5:0] c_CNT_MAX  = 6'h3F;

    logic [1:0]           r_state;
    logic [1:0]           w_nextState;
    logic [5:0]           r_cnt;
    logic [5:0]           w_cntNext;
    logic [5:0]           w_cntSat;
    logic [c_SHIFT_W-1:0] r_shift;

    logic                 w_shiftEn;
    logic                 w_emit;
    logic                 w_errValid;
    itchErrCodeType       w_errCode;

    itchAddOrderType      w_record;
    logic                 w_complete;
    logic                 w_locateOk;

    logic                 r_orderValid;
    logic [15:0]          r_locate;
    logic [15:0]          r_trackNum;
    logic [47:0]          r_timeStamp;
    logic [63:0]          r_refNum;
    logic                 r_buy;
    logic [31:0]          r_shares;
    logic [63:0]          r_stock;
    logic [31:0]          r_price;
    logic                 r_errValid;
    itchErrCodeType       r_errCode;
    logic                 r_seqGap;

    assign w_record   = itchAddOrderType'({r_shift, bus.itchData});
    assign w_cntSat   = (r_cnt == c_CNT_MAX) ? c_CNT_MAX : (r_cnt + 6'd1);
    assign w_locateOk = !LOCATE_FILTER_EN || (w_record.locate == LOCATE_ID);

    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.itchDataValid) begin
                    w_nextState = (bus.itchData == ADD_MSG_TYPE) ? S_COLLECT : S_SKIP;
                end
            end
            S_COLLECT: begin
                if (!bus.itchDataValid) begin
                    w_nextState = S_IDLE;
                end else if (r_cnt == c_LAST_IDX) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_nextState = bus.itchDataValid ? S_SKIP : S_IDLE;
            end
            S_SKIP: begin
                if (!bus.itchDataValid) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_shiftEn  = 1'b0;
        w_complete = 1'b0;
        w_emit     = 1'b0;
        w_errValid = 1'b0;
        w_errCode  = ERR_NONE;
        w_cntNext  = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cntNext = bus.itchDataValid ? 6'd1 : 6'd0;
                w_shiftEn = bus.itchDataValid && (bus.itchData == ADD_MSG_TYPE);
            end
            S_COLLECT: begin
                if (bus.itchDataValid) begin
                    w_shiftEn  = 1'b1;
                    w_cntNext  = r_cnt + 6'd1;
                    w_complete = (r_cnt == c_LAST_IDX) && (w_record.msgType == ADD_MSG_TYPE);
                end else begin
                    w_errValid = 1'b1;
                    w_errCode  = ERR_TRUNC;
                    w_cntNext  = 6'd0;
                end
            end
            S_DRAIN: begin
                w_cntNext = bus.itchDataValid ? w_cntSat : 6'd0;
                if (bus.itchDataValid) begin
                    w_errValid = 1'b1;
                    w_errCode  = ERR_OVERLONG;
                end
            end
            S_SKIP: begin
                w_cntNext = bus.itchDataValid ? w_cntSat : 6'd0;
            end
            default: w_cntNext = 6'd0;
        endcase

        // A malformed side is reported even when the locate would be filtered.
        if (w_complete) begin
            if (!isValidSide(w_record.side)) begin
                w_errValid = 1'b1;
                w_errCode  = ERR_BAD_SIDE;
            end else begin
                w_emit = w_locateOk;
            end
        end
    end

    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            r_cnt        <= 6'd0;
            r_shift      <= '0;
            r_orderValid <= 1'b0;
            r_locate     <= '0;
            r_trackNum   <= '0;
            r_timeStamp  <= '0;
            r_refNum     <= '0;
            r_buy        <= 1'b0;
            r_shares     <= '0;
            r_stock      <= '0;
            r_price      <= '0;
            r_errValid   <= 1'b0;
            r_errCode    <= ERR_NONE;
            r_seqGap     <= 1'b0;
        end else begin
            r_cnt        <= w_cntNext;
            r_orderValid <= w_emit;
            r_errValid   <= w_errValid;
            r_seqGap     <= bus.packetLost;
            if (w_shiftEn) begin
                r_shift <= {r_shift[c_SHIFT_W-9:0], bus.itchData};
            end
            if (w_emit) begin
                r_locate    <= w_record.locate;
                r_trackNum  <= w_record.trackNum;
                r_timeStamp <= w_record.timeStamp;
                r_refNum    <= w_record.refNum;
                r_buy       <= (w_record.side == BUY);
                r_shares    <= w_record.shares;
                r_stock     <= w_record.stock;
                r_price     <= w_record.price;
            end
            if (w_errValid) begin
                r_errCode <= w_errCode;
            end
        end
    end

    assign bus.orderValid = r_orderValid;
    assign bus.locate     = r_locate;
    assign bus.trackNum   = r_trackNum;
    assign bus.timeStamp  = r_timeStamp;
    assign bus.refNum     = r_refNum;
    assign bus.buy        = r_buy;
    assign bus.shares     = r_shares;
    assign bus.stock      = r_stock;
    assign bus.price      = r_price;
    assign bus.errValid   = r_errValid;
    assign bus.errCode    = r_errCode;
    assign bus.seqGap     = r_seqGap;

endmodule
`default_nettype wire

// File: tb/tb_itch_add_order_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_itch_add_order_decoder
//  Description : Scoreboard bench for an unfiltered and a locate-filtered decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_itch_add_order_decoder;
    import itch_add_order_decoder_pkg::*;

    localparam int EXP_NONE     = 0;
    localparam int EXP_ORDER    = 1;
    localparam int EXP_TRUNC    = 2;
    localparam int EXP_ORDER_OL = 3;
    localparam int EXP_BADSIDE  = 4;

    typedef struct {
        int              cyc;
        bit              isErr;
        logic [1:0]      code;
        itchAddOrderType rec;
    } expT;

    logic clk = 1'b0;
    logic rstB;
    always #2 clk = ~clk;

    itch_add_order_decoder_if bus0();
    itch_add_order_decoder_if bus1();

    assign bus1.itchDataValid = bus0.itchDataValid;
    assign bus1.itchData      = bus0.itchData;
    assign bus1.packetLost    = bus0.packetLost;

    itch_add_order_decoder #(.LOCATE_FILTER_EN(1'b0), .LOCATE_ID(16'hBE42)) dut0 (
        .clkIn(clk), .rstBIn(rstB), .bus(bus0.slave));
    itch_add_order_decoder #(.LOCATE_FILTER_EN(1'b1), .LOCATE_ID(16'hBE42)) dut1 (
        .clkIn(clk), .rstBIn(rstB), .bus(bus1.slave));

    expT             q0[$];
    expT             q1[$];
    int              g0[$];
    int              g1[$];
    int              nCmp = 0;
    int              nFail = 0;
    int              cyc = 0;
    itchAddOrderType last0 = '0;
    itchAddOrderType last1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monStep(input int d, input logic ov, input logic ev, input logic sg,
                           input logic [1:0] code, input logic [15:0] loc, input logic [15:0] trk,
                           input logic [47:0] ts, input logic [63:0] rf, input logic buy,
                           input logic [31:0] sh, input logic [63:0] st, input logic [31:0] pr);
        expT             e;
        itchAddOrderType r;
        int              gc;
        bit              has;
        if (ov || ev) begin
            has = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!has) begin
                nCmp++;
                nFail++;
                $display("FAIL d%0d.unexpectedPulse: got orderValid=%0b errValid=%0b expected none (cycle %0d)",
                         d, ov, ev, cyc);
            end else begin
                if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                check($sformatf("d%0d.cycle", d), 64'(cyc), 64'(e.cyc));
                check($sformatf("d%0d.orderValid", d), 64'(ov), 64'(!e.isErr));
                check($sformatf("d%0d.errValid", d), 64'(ev), 64'(e.isErr));
                if (e.isErr) check($sformatf("d%0d.errCode", d), 64'(code), 64'(e.code));
                if (e.isErr) r = (d == 0) ? last0 : last1;
                else         r = e.rec;
                check($sformatf("d%0d.locate", d), 64'(loc), 64'(r.locate));
                check($sformatf("d%0d.trackNum", d), 64'(trk), 64'(r.trackNum));
                check($sformatf("d%0d.timeStamp", d), 64'(ts), 64'(r.timeStamp));
                check($sformatf("d%0d.refNum", d), rf, r.refNum);
                check($sformatf("d%0d.buy", d), 64'(buy), 64'(r.side == BUY));
                check($sformatf("d%0d.shares", d), 64'(sh), 64'(r.shares));
                check($sformatf("d%0d.stock", d), st, r.stock);
                check($sformatf("d%0d.price", d), 64'(pr), 64'(r.price));
                if (!e.isErr) begin
                    if (d == 0) last0 = e.rec; else last1 = e.rec;
                end
            end
        end
        if (sg) begin
            has = (d == 0) ? (g0.size() > 0) : (g1.size() > 0);
            if (!has) begin
                nCmp++;
                nFail++;
                $display("FAIL d%0d.unexpectedSeqGap: got 1 expected 0 (cycle %0d)", d, cyc);
            end else begin
                if (d == 0) gc = g0.pop_front(); else gc = g1.pop_front();
                check($sformatf("d%0d.seqGapCycle", d), 64'(cyc), 64'(gc));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstB === 1'b1) begin
            monStep(0, bus0.orderValid, bus0.errValid, bus0.seqGap, bus0.errCode, bus0.locate,
                    bus0.trackNum, bus0.timeStamp, bus0.refNum, bus0.buy, bus0.shares,
                    bus0.stock, bus0.price);
            monStep(1, bus1.orderValid, bus1.errValid, bus1.seqGap, bus1.errCode, bus1.locate,
                    bus1.trackNum, bus1.timeStamp, bus1.refNum, bus1.buy, bus1.shares,
                    bus1.stock, bus1.price);
        end
    end

    function automatic itchAddOrderType mk(input logic [15:0] loc, input logic [63:0] rf,
                                           input logic [7:0] side, input logic [31:0] sh,
                                           input logic [63:0] st, input logic [31:0] pr);
        itchAddOrderType m;
        m.msgType   = ADD_MSG_TYPE;
        m.locate    = loc;
        m.trackNum  = 16'h0007;
        m.timeStamp = 48'h2A1B_3C4D_5E6F;
        m.refNum    = rf;
        m.side      = side;
        m.shares    = sh;
        m.stock     = st;
        m.price     = pr;
        return m;
    endfunction

    task automatic push(input int d, input bit isErr, input logic [1:0] code, input itchAddOrderType m);
        expT e;
        e.cyc   = cyc + 1;
        e.isErr = isErr;
        e.code  = code;
        e.rec   = m;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic expectAt(input int d, input int ex, input int k, input itchAddOrderType m);
        if (k == 35 && (ex == EXP_ORDER || ex == EXP_ORDER_OL)) push(d, 1'b0, ERR_NONE, m);
        if (k == 35 && ex == EXP_BADSIDE) push(d, 1'b1, ERR_BAD_SIDE, m);
        if (k == 36 && ex == EXP_ORDER_OL) push(d, 1'b1, ERR_OVERLONG, m);
        if (k == -1 && ex == EXP_TRUNC) push(d, 1'b1, ERR_TRUNC, m);
    endtask

    task automatic driveByte(input logic v, input logic [7:0] b);
        @(posedge clk);
        #1;
        bus0.itchDataValid = v;
        bus0.itchData      = b;
    endtask

    task automatic sendMsg(input itchAddOrderType m, input int len, input int e0, input int e1,
                           input int idle);
        logic [287:0] v;
        logic [7:0]   b;
        v = m;
        for (int k = 0; k < len; k++) begin
            b = (k < 36) ? v[287 - 8*k -: 8] : 8'h00;
            driveByte(1'b1, b);
            expectAt(0, e0, k, m);
            expectAt(1, e1, k, m);
        end
        driveByte(1'b0, 8'h00);
        expectAt(0, e0, -1, m);
        expectAt(1, e1, -1, m);
        for (int i = 1; i < idle; i++) driveByte(1'b0, 8'h00);
    endtask

    task automatic checkZero(input string tag);
        check({tag, ".d0.orderValid"}, 64'(bus0.orderValid), 64'd0);
        check({tag, ".d0.errValid"}, 64'(bus0.errValid), 64'd0);
        check({tag, ".d0.seqGap"}, 64'(bus0.seqGap), 64'd0);
        check({tag, ".d0.errCode"}, 64'(bus0.errCode), 64'd0);
        check({tag, ".d0.locate"}, 64'(bus0.locate), 64'd0);
        check({tag, ".d0.refNum"}, bus0.refNum, 64'd0);
        check({tag, ".d0.buy"}, 64'(bus0.buy), 64'd0);
        check({tag, ".d0.stock"}, bus0.stock, 64'd0);
        check({tag, ".d0.price"}, 64'(bus0.price), 64'd0);
        check({tag, ".d1.orderValid"}, 64'(bus1.orderValid), 64'd0);
        check({tag, ".d1.refNum"}, bus1.refNum, 64'd0);
        check({tag, ".d1.shares"}, 64'(bus1.shares), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        itchAddOrderType m1, m2, m3, m4, mE, m5, m6, m7, m8;
        m1 = mk(16'hBE42, 64'hDEFB1673DEFB1673, BUY, 32'h45, 64'h4141504C20202020, 32'h0022FEFC);
        m2 = mk(16'hBE42, 64'h111B1673DEFB4321, SELL, 32'h184, 64'h4D53465420202020, 32'h0021FEFC);
        m3 = mk(16'hBE42, 64'h0123456789ABCDEF, BUY, 32'h10, 64'h49424D2020202020, 32'h00010000);
        m4 = mk(16'hBE42, 64'hCAFEF00D12345678, SELL, 32'h99, 64'h5453544120202020, 32'h00031337);
        mE = mk(16'hBE42, 64'h5555555555555555, BUY, 32'h1, 64'h4545454545454545, 32'h1);
        mE.msgType = 8'h45;
        m5 = mk(16'hBE42, 64'hAAAA0000BBBB1111, 8'h58, 32'h7, 64'h5858585820202020, 32'h7);
        m6 = mk(16'h1234, 64'h0000000000000ABC, BUY, 32'h2000, 64'h474F4F4720202020, 32'h00123456);
        m7 = mk(16'hBE42, 64'hFEDCBA9876543210, SELL, 32'h3, 64'h4E56444120202020, 32'h00000001);
        m8 = mk(16'hBE42, 64'h0F0F0F0F0F0F0F0F, BUY, 32'h64, 64'h414D5A4E20202020, 32'h00500000);

        rstB               = 1'b0;
        bus0.itchDataValid = 1'b0;
        bus0.itchData      = 8'h00;
        bus0.packetLost    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkZero("reset");
        rstB = 1'b1;
        repeat (2) driveByte(1'b0, 8'h00);

        sendMsg(m1, 36, EXP_ORDER, EXP_ORDER, 3);

        @(posedge clk);
        #1;
        bus0.packetLost = 1'b1;
        g0.push_back(cyc + 1);
        g1.push_back(cyc + 1);
        @(posedge clk);
        #1;
        bus0.packetLost = 1'b0;
        sendMsg(m2, 36, EXP_ORDER, EXP_ORDER, 3);

        sendMsg(m3, 20, EXP_TRUNC, EXP_TRUNC, 3);
        sendMsg(m4, 37, EXP_ORDER_OL, EXP_ORDER_OL, 3);
        sendMsg(mE, 20, EXP_NONE, EXP_NONE, 3);
        sendMsg(m5, 36, EXP_BADSIDE, EXP_BADSIDE, 3);
        sendMsg(m6, 36, EXP_ORDER, EXP_NONE, 1);
        sendMsg(m7, 36, EXP_ORDER, EXP_ORDER, 3);

        // Abort a message at byte 10 with reset; nothing of it may surface.
        for (int k = 0; k < 10; k++) driveByte(1'b1, m8.refNum[63 - 8*(k % 8) -: 8]);
        @(posedge clk);
        #1;
        bus0.itchData = 8'h11;
        rstB          = 1'b0;
        #1;
        checkZero("midReset");
        bus0.itchDataValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkZero("heldReset");
        last0 = '0;
        last1 = '0;
        rstB  = 1'b1;
        repeat (2) driveByte(1'b0, 8'h00);
        sendMsg(m8, 36, EXP_ORDER, EXP_ORDER, 6);

        check("d0.pendingExpected", 64'(q0.size()), 64'd0);
        check("d1.pendingExpected", 64'(q1.size()), 64'd0);
        check("d0.pendingSeqGap", 64'(g0.size()), 64'd0);
        check("d1.pendingSeqGap", 64'(g1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
